// File: rtl/regfile.sv
// Two-read, one-write 32x32 register file with byte write enables and a hardwired zero register.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write onto the read ports.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];
  logic [31:0] lane_mask;
  logic        wr_en;

  always_comb begin
    for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{we[b]}};
  end

  assign wr_en = (waddr != 5'd0) && (we != 4'b0000);

  // NOTE: every entry has a reset, so this array maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= (regs[waddr] & ~lane_mask) | (wdata & lane_mask);
    end
  end

  function automatic logic [31:0] read_port(
    input logic        rst_ok,
    input logic        re,
    input logic [4:0]  raddr,
    input logic [31:0] stored,
    input logic        hit,
    input logic [31:0] mask,
    input logic [31:0] wval
  );
    logic [31:0] v;
    v = '0;
    if (rst_ok && re && raddr != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      v = hit ? ((stored & ~mask) | (wval & mask)) : stored;
`else
      v = stored;
`endif
    end
    return v;
  endfunction

  logic hit1, hit2;
  assign hit1 = wr_en && (raddr1 == waddr);
  assign hit2 = wr_en && (raddr2 == waddr);

  // NOTE: combinational outputs are assigned on every path, so no latch is inferred.
  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, regs[raddr1], hit1, lane_mask, wdata);
    rdata2 = read_port(rst, re2, raddr2, regs[raddr2], hit2, lane_mask, wdata);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (en[b]) r[8*b +: 8] = nv[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expect_read(input logic re, input logic [4:0] ra);
    logic [31:0] v;
    if (!rst || !re || ra == 5'd0) return 32'h0;
    v = model[ra];
`ifdef REGFILE_BYPASS_EN
    if (we != 4'b0 && waddr != 5'd0 && ra == waddr) v = merge(v, wdata, we);
`endif
    return v;
  endfunction

  task automatic drive(input logic r, input logic [3:0] w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #2;
  endtask

  // Advance one clock, applying the architectural effect of the presented inputs to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (waddr != 5'd0 && we != 4'b0) begin
      model[waddr] = merge(model[waddr], wdata, we);
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_p1"}, rdata1, expect_read(re1, raddr1));
    check({tag, "_p2"}, rdata2, expect_read(re2, raddr2));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);

    // Reset held two cycles with junk writes presented; reads must be zero throughout.
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'hF, 5'(c + 3), 32'hCAFE0000 + 32'(c), 1'b1, 5'(c + 3), 1'b1, 5'd31);
      check("rst_hold_p1", rdata1, 32'h0);
      check("rst_hold_p2", rdata2, 32'h0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));
      check("rst_clear_p1", rdata1, 32'h0);
      check("rst_clear_p2", rdata2, 32'h0);
    end

    // Full-word write then read.
    drive(1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("full_word_p1", rdata1, 32'hDEADBEEF);
    check("full_word_p2", rdata2, 32'hDEADBEEF);

    // Byte-lane merge.
    drive(1'b1, 4'b0101, 5'd5, 32'h11223344, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5);
    check("byte_merge", rdata1, 32'hDE22BE44);
    check("re2_off", rdata2, 32'h0);

    // Write to r0 is discarded.
    drive(1'b1, 4'hF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    check("zero_reg_p1", rdata1, 32'h0);
    check("zero_reg_p2", rdata2, 32'h0);

    // we = 0 changes nothing.
    drive(1'b1, 4'h0, 5'd5, 32'h99999999, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    check("we_zero", rdata1, 32'hDE22BE44);

    // Same-cycle hazard on r7.
    drive(1'b1, 4'hF, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
`ifdef REGFILE_BYPASS_EN
    check("hazard_p1", rdata1, 32'h12345678);
    check("hazard_p2", rdata2, 32'h12345678);
`else
    check("hazard_p1", rdata1, 32'h0);
    check("hazard_p2", rdata2, 32'h0);
`endif
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    check("hazard_next", rdata1, 32'h12345678);

    // Reset wins over a simultaneous write; outputs zero while reset is low.
    drive(1'b0, 4'hF, 5'd9, 32'hAAAA5555, 1'b1, 5'd5, 1'b1, 5'd9);
    check("rst_mid_p1", rdata1, 32'h0);
    check("rst_mid_p2", rdata2, 32'h0);
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);
    check("rst_prio_r9", rdata1, 32'h0);
    check("rst_prio_r5", rdata2, 32'h0);

    // re1 = 0 masks a nonzero register.
    drive(1'b1, 4'hF, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
    check("re1_off", rdata1, 32'h0);
    check("re1_off_ref", rdata2, 32'h0BADF00D);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] a1, a2, wa;
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) != 0), 4'($urandom), wa, $urandom,
            ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2);
      check_model("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL be clocked by a single clock and SHALL use a synchronous, active-low reset.
REQ-002 Port clk SHALL be an input, 1 bit wide: the sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: synchronous reset, active low.
REQ-004 Port we SHALL be an input, 4 bits wide: byte write enables from the WB stage; bit i SHALL enable byte i, where bits [8i+7:8i].
REQ-005 Port waddr SHALL be an input, 5 bits wide: the write register index from the WB stage.
REQ-006 Port wdata SHALL be an input, 32 bits wide: the write data from the WB stage.
REQ-007 Port re1 SHALL be an input, 1 bit wide: read enable for port 1 (ID stage).
REQ-008 Port raddr1 SHALL be an input, 5 bits wide: the read index for port 1.
REQ-009 Port rdata1 SHALL be an output, 32 bits wide: the read data for port 1, combinational.
REQ-010 Ports re2, raddr2 and rdata2 SHALL behave as re1, raddr1 and rdata1, for port 2.

Function
REQ-011 Storage SHALL be 32 registers x 32 bits; register 0 SHALL read as 0x00000000 at all times.
REQ-012 On a rising clk edge with rst high, waddr != 0 and we != 0, each byte i with we[i]=1 SHALL take wdata byte i; bytes with we[i]=0 SHALL hold their value.
REQ-013 A write to waddr 0 SHALL be discarded.
REQ-014 A write with we = 4'b0000 SHALL change no state.
REQ-015 Write latency SHALL be one cycle: the written value SHALL be visible in storage from the next cycle on.
REQ-016 rdata1 SHALL be 0x00000000 when rst is low, when re1 is 0, or when raddr1 is 0; otherwise it SHALL be the storage contents, subject to REQ-022.
REQ-017 rdata2 SHALL follow the same rules as rdata1, using re2 and raddr2.
REQ-018 Both read ports SHALL be fully independent; reading the same index on both ports SHALL return identical data.
REQ-019 The read paths SHALL be combinational; the block SHALL add no read latency and SHALL assert no stall.

Reset
REQ-020 When rst is low at a rising clk edge, registers 1..31 SHALL clear to 0x00000000, and any write presented in that cycle SHALL be ignored.
REQ-021 Reset applied mid-operation SHALL take priority over a simultaneous write, and both read outputs SHALL be 0 while rst is low.

Configuration
REQ-022 With macro REGFILE_BYPASS_EN defined, a read in a cycle where re=1, raddr=waddr!=0 and we!=0 SHALL return a byte-merged value: wdata for bytes with we[i]=1, stored bytes otherwise.
REQ-023 Without REGFILE_BYPASS_EN, reads SHALL return stored contents only; the new value SHALL become visible one cycle later, and the bypass logic SHALL be absent from the netlist.

Verification
REQ-024 Reset check: hold rst low for 2 cycles, then read all indices 1..31 on both ports -> every read SHALL return 0x00000000.
REQ-025 Full-word write: we=4'hF, waddr=5, wdata=0xDEADBEEF; next cycle re1=1, raddr1=5 -> rdata1 SHALL be 0xDEADBEEF.
REQ-026 Byte-lane merge: with r5=0xDEADBEEF, apply we=4'b0101, wdata=0x11223344; then read r5 -> result SHALL be 0xDE22BE44.
REQ-027 Zero register: we=4'hF, waddr=0, wdata=0xFFFFFFFF; then raddr1=raddr2=0 with re=1 -> both ports SHALL return 0x00000000.
REQ-028 Same-cycle hazard: r7=0x00000000; in one cycle apply we=4'hF, waddr=7, wdata=0x12345678 with re1=1, raddr1=7 -> rdata1 SHALL be 0x12345678 with REGFILE_BYPASS_EN defined and 0x00000000 without it.
REQ-029 Reset priority: apply rst low in the same cycle as we=4'hF, waddr=9, wdata=0xAAAA5555; release rst and read r9 -> result SHALL be 0x00000000; also check that re1=0 forces rdata1=0 for a nonzero register.
